// File: rtl/bank_read_if.sv
// Bank read unit bus bundle.
// Groups the request, bank-read, write-snoop and output-stream signals of
// bank_read_unit.
//   master : request source / bank / consumer side (testbench or system)
//   slave  : bank_read_unit side
// Signals:
//   req_valid/req_ready/req_addr/req_len : burst request handshake
//   rd_en/rd_sel/rd_data                 : bank read port
//   wr_we/wr_sel/wr_data                 : write-side snoop (bypass feature)
//   out_valid/out_ready/out_data/out_last: output word stream
//   busy                                 : unit not idle
interface bank_read_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] req_len;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_sel;
  logic [DATA_W-1:0] rd_data;
  logic              wr_we;
  logic [ADDR_W-1:0] wr_sel;
  logic [DATA_W-1:0] wr_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;

  modport master (
    output req_valid, req_addr, req_len, rd_data, wr_we, wr_sel, wr_data,
           out_ready,
    input  req_ready, rd_en, rd_sel, out_valid, out_data, out_last, busy
  );

  modport slave (
    input  req_valid, req_addr, req_len, rd_data, wr_we, wr_sel, wr_data,
           out_ready,
    output req_ready, rd_en, rd_sel, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/bank_read_unit.sv
// bank_read_unit: read-side burst sequencer for the register bank.
// Accepts a burst request (start address, length-1), steps a registered
// read select across the bank (wrapping modulo 2**ADDR_W), captures the
// bank's combinational read data and streams the words out over a
// valid/ready interface with a last flag. One word per two cycles.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : bank_read_if.slave (request, bank read, write snoop, output)
// Optional feature macro RD_BYPASS_EN: when defined, a bank write landing
// on the fetched register in the FETCH cycle is forwarded to out_data.
module bank_read_unit #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input logic        clk,
  input logic        rst,
  bank_read_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            state_q, state_n;
  logic [ADDR_W-1:0] rd_sel_q, rd_sel_n;
  logic [ADDR_W-1:0] rem_q, rem_n;
  logic              rd_en_q, rd_en_n;
  logic              out_valid_q, out_valid_n;
  logic              out_last_q, out_last_n;
  logic [DATA_W-1:0] out_data_q, out_data_n;
  logic [DATA_W-1:0] fetch_data;

`ifdef RD_BYPASS_EN
  assign fetch_data = (bus.wr_we && (bus.wr_sel == rd_sel_q)) ? bus.wr_data
                                                               : bus.rd_data;
`else
  // Write snoop inputs are kept on the bus but have no effect here.
  logic unused_wr;
  assign unused_wr  = ^{bus.wr_we, bus.wr_sel, bus.wr_data};
  assign fetch_data = bus.rd_data;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_sel_q    <= '0;
      rem_q       <= '0;
      rd_en_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_n;
      rd_sel_q    <= rd_sel_n;
      rem_q       <= rem_n;
      rd_en_q     <= rd_en_n;
      out_valid_q <= out_valid_n;
      out_last_q  <= out_last_n;
      out_data_q  <= out_data_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    rd_sel_n    = rd_sel_q;
    rem_n       = rem_q;
    rd_en_n     = rd_en_q;
    out_valid_n = out_valid_q;
    out_last_n  = out_last_q;
    out_data_n  = out_data_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          rd_sel_n = bus.req_addr;
          rem_n    = bus.req_len;
          rd_en_n  = 1'b1;
          state_n  = FETCH;
        end
      end
      FETCH: begin
        out_data_n  = fetch_data;
        out_valid_n = 1'b1;
        out_last_n  = (rem_q == '0);
        state_n     = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) begin
          out_valid_n = 1'b0;
          if (out_last_q) begin
            rd_en_n    = 1'b0;
            out_last_n = 1'b0;
            state_n    = IDLE;
          end else begin
            rd_sel_n = rd_sel_q + ADDR_ONE;
            rem_n    = rem_q - ADDR_ONE;
            state_n  = FETCH;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_sel    = rd_sel_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_bank_read_unit.sv
// Self-checking bench for bank_read_unit. The bank is an array in the
// bench; each burst's expected word list is bank[(addr+i) mod 16] for
// i = 0..len, with last only on i == len.
module tb_bank_read_unit;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int NREG = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DW-1:0] bank [NREG];

  int vectors = 0;
  int miscompares = 0;

  bank_read_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  bank_read_unit #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.rd_data = bank[bus.rd_sel];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_data"},  bus.out_data, 0);
    chk({tag, "_out_last"},  bus.out_last, 0);
    chk({tag, "_rd_en"},     bus.rd_en, 0);
    chk({tag, "_rd_sel"},    bus.rd_sel, 0);
    chk({tag, "_busy"},      bus.busy, 0);
    chk({tag, "_req_ready"}, bus.req_ready, 1);
  endtask

  // One complete burst. stall0 is the HOLD stall on word 0 when rand_stall
  // is 0; otherwise every word gets a random stall. With hold=1 req_valid
  // stays high after accept carrying the next request (n_addr/n_len).
  task automatic run_burst(input int addr, input int len, input int stall0,
                           input bit rand_stall, input bit hold,
                           input int n_addr, input int n_len,
                           input bit expect_now);
    int waited;
    int stall;
    logic [DW-1:0] exp_d;
    waited = 0;
    bus.req_addr  = addr[AW-1:0];
    bus.req_len   = len[AW-1:0];
    bus.req_valid = 1'b1;
    while (bus.req_ready !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    if (expect_now) chk("accept_wait", waited, 0);
    else chk("req_ready_idle", bus.req_ready, 1);
    tick();
    chk("acc_busy", bus.busy, 1);
    chk("acc_rd_en", bus.rd_en, 1);
    chk("acc_rd_sel", bus.rd_sel, addr);
    chk("acc_out_valid", bus.out_valid, 0);
    if (hold) begin
      bus.req_addr = n_addr[AW-1:0];
      bus.req_len  = n_len[AW-1:0];
    end else begin
      bus.req_valid = 1'b0;
    end
    for (int i = 0; i <= len; i++) begin
      if (rand_stall) stall = int'($urandom_range(0, 3));
      else stall = (i == 0) ? stall0 : 0;
      exp_d = bank[(addr + i) % NREG];
      bus.out_ready = (stall == 0);
      tick();
      chk("w_valid", bus.out_valid, 1);
      chk("w_data", bus.out_data, exp_d);
      chk("w_last", bus.out_last, (i == len));
      chk("w_rd_sel", bus.rd_sel, (addr + i) % NREG);
      chk("w_req_ready", bus.req_ready, 0);
      for (int s = 0; s < stall; s++) begin
        tick();
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_data", bus.out_data, exp_d);
        chk("stall_last", bus.out_last, (i == len));
        chk("stall_rd_sel", bus.rd_sel, (addr + i) % NREG);
      end
      bus.out_ready = 1'b1;
      tick();
      chk("hs_valid", bus.out_valid, 0);
      if (i == len) begin
        chk("end_busy", bus.busy, 0);
        chk("end_rd_en", bus.rd_en, 0);
        chk("end_last", bus.out_last, 0);
        chk("end_req_ready", bus.req_ready, 1);
      end else begin
        chk("mid_busy", bus.busy, 1);
        chk("mid_rd_en", bus.rd_en, 1);
      end
      // out_ready is don't-care while out_valid is low
      bus.out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    logic [DW-1:0] exp_byp;
    int a, l;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.wr_we     = 1'b0;
    bus.wr_sel    = '0;
    bus.wr_data   = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < NREG; i++) bank[i] = DW'(8'h10 + i);

    // reset asserted from time 0, checked before the first edge
    #3;
    check_reset_outputs("rst0");
    #4 rst = 1'b0;

    // single word
    bank[5] = 8'hA5;
    run_burst(5, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0);

    // wrap burst 14,15,0,1
    for (int i = 0; i < NREG; i++) bank[i] = DW'(8'h10 + i);
    run_burst(14, 3, 0, 1'b0, 1'b0, 0, 0, 1'b0);

    // backpressure on first word
    run_burst(2, 1, 5, 1'b0, 1'b0, 0, 0, 1'b0);

    // request held while busy: next request accepted right after last word
    run_burst(7, 2, 1, 1'b0, 1'b1, 9, 1, 1'b0);
    run_burst(9, 1, 0, 1'b0, 1'b0, 0, 0, 1'b1);

    // write snoop during FETCH at rd_sel=3
    bank[3] = 8'h3C;
    bus.req_addr  = 4'd3;
    bus.req_len   = 4'd0;
    bus.req_valid = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    chk("byp_rd_sel", bus.rd_sel, 3);
    bus.wr_we   = 1'b1;
    bus.wr_sel  = 4'd3;
    bus.wr_data = 8'h77;
`ifdef RD_BYPASS_EN
    exp_byp = 8'h77;
`else
    exp_byp = 8'h3C;
`endif
    tick();
    bus.wr_we = 1'b0;
    chk("byp_data", bus.out_data, exp_byp);
    chk("byp_last", bus.out_last, 1);
    tick();
    chk("byp_idle", bus.req_ready, 1);

    // reset during HOLD of a 4-word burst
    bus.req_addr  = 4'd0;
    bus.req_len   = 4'd3;
    bus.req_valid = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk("pre_rst_valid", bus.out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    #2 rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("post_rst_valid", bus.out_valid, 0);
      chk("post_rst_last", bus.out_last, 0);
    end

    // randomized bursts
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < NREG; i++) bank[i] = DW'($urandom);
      a = int'($urandom_range(0, NREG - 1));
      l = int'($urandom_range(0, NREG - 1));
      run_burst(a, l, 0, 1'b1, 1'b0, 0, 0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
